// File: rtl/stereolbm_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stereolbm_acc_pkg
// Description : Shared defaults and constant helpers for the stereo LBM
//               product accumulator (widths, counter sizing, OUT_W limits).
//               The rounding feature is selected by STEREOLBM_ACC_ROUND_EN
//               in the modules that import this package.
// Revision    : 1.0 - initial release
// ============================================================================
package stereolbm_acc_pkg;

    // Default datapath widths
    localparam int c_PROD_W = 32;
    localparam int c_ACC_W  = 40;
    localparam int c_OUT_W  = 32;

    // Width of the scratch vectors used to build saturation limits
    localparam int c_LIM_W  = 256;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Largest signed value representable in w bits: 2^(w-1)-1
    function automatic logic [c_LIM_W-1:0] out_max(input int w);
        return (c_LIM_W'(1) << (w - 1)) - c_LIM_W'(1);
    endfunction

    // Smallest signed value representable in w bits: -2^(w-1)
    function automatic logic [c_LIM_W-1:0] out_min(input int w);
        return ~out_max(w);
    endfunction

endpackage : stereolbm_acc_pkg
`default_nettype wire

// File: rtl/stereolbm_axis_cambm_sat_shift.sv
`default_nettype none
// ============================================================================
// Module      : stereolbm_axis_cambm_sat_shift
// Description : Combinational arithmetic right shift of the window sum, with
//               optional round-half-up (macro STEREOLBM_ACC_ROUND_EN), then
//               saturation to OUT_W signed bits with a clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stereolbm_axis_cambm_sat_shift
    import stereolbm_acc_pkg::*;
#(
    parameter int ACC_W = c_ACC_W,
    parameter int OUT_W = c_OUT_W,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    localparam logic [c_LIM_W-1:0] c_MAX_FULL = out_max(OUT_W);
    localparam logic [c_LIM_W-1:0] c_MIN_FULL = out_min(OUT_W);
    // Limits sign-extended to the ACC_W+1 working width
    localparam logic signed [ACC_W:0] c_MAX = c_MAX_FULL[ACC_W:0];
    localparam logic signed [ACC_W:0] c_MIN = c_MIN_FULL[ACC_W:0];

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_biased;
    logic signed [ACC_W:0] w_t;

    // One guard bit so the rounding bias can never wrap the sum
    assign w_ext = {sum[ACC_W-1], sum};

`ifdef STEREOLBM_ACC_ROUND_EN
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] c_BIAS = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
            assign w_biased = w_ext + c_BIAS;
        end else begin : g_no_round
            assign w_biased = w_ext;
        end
    endgenerate
`else
    assign w_biased = w_ext;
`endif

    assign w_t = w_biased >>> SHIFT;

    // Clip the shifted value into the OUT_W signed range
    always_comb begin
        data = w_t[OUT_W-1:0];
        sat  = 1'b0;
        if (w_t > c_MAX) begin
            data = c_MAX[OUT_W-1:0];
            sat  = 1'b1;
        end else if (w_t < c_MIN) begin
            data = c_MIN[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule : stereolbm_axis_cambm_sat_shift
`default_nettype wire

// File: rtl/stereolbm_axis_cambm_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : stereolbm_axis_cambm_prod_accum
// Description : Accumulates WIN_LEN signed multiplier products per window,
//               scales/saturates the sum and presents it on a valid/ready
//               output. Owns the multiplier clock enable so output
//               backpressure freezes the multiplier and the valid pipeline
//               together. Optional rounding: STEREOLBM_ACC_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stereolbm_axis_cambm_prod_accum
    import stereolbm_acc_pkg::*;
#(
    parameter int PROD_W  = c_PROD_W,
    parameter int ACC_W   = c_ACC_W,
    parameter int OUT_W   = c_OUT_W,
    parameter int WIN_LEN = 9,
    parameter int SHIFT   = 0,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mul_ce,
    input  logic [PROD_W-1:0] prod,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_sat,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int c_CNT_W = (clog2(WIN_LEN) < 1) ? 1 : clog2(WIN_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIN_LEN - 1);

    logic                  w_ce;
    logic                  w_p_valid;
    logic                  w_step;
    logic                  w_last;
    logic                  w_ovf;
    logic [ACC_W-1:0]      w_prod_ext;
    logic [ACC_W-1:0]      w_sum;
    logic [OUT_W-1:0]      w_res_data;
    logic                  w_res_sat;

    logic [MUL_LAT-1:0]    r_vpipe;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [OUT_W-1:0]      r_m_data;
    logic                  r_m_sat;
    logic                  r_m_valid;

    // Stall everything only while a result is held and not taken
    assign w_ce    = ~(r_m_valid & ~m_ready);
    assign mul_ce  = w_ce;
    assign s_ready = w_ce;

    assign w_p_valid  = r_vpipe[MUL_LAT-1];
    assign w_step     = w_ce & w_p_valid;
    assign w_last     = (r_cnt == c_LAST);
    assign w_prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign w_sum      = r_acc + w_prod_ext;
    // Signed overflow: like-signed operands producing an opposite-signed sum
    assign w_ovf      = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // Valid pipeline tracks operands through the ce-qualified multiplier
    generate
        if (MUL_LAT == 1) begin : g_vpipe_one
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else if (w_ce) begin
                    r_vpipe <= s_valid;
                end
            end
        end else begin : g_vpipe_multi
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else if (w_ce) begin
                    r_vpipe <= {r_vpipe[MUL_LAT-2:0], s_valid};
                end
            end
        end
    endgenerate

    // Window counter and accumulator; first product reloads, others add
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_step) begin
            if (r_cnt == '0) begin
                r_acc <= w_prod_ext;
                r_cnt <= c_CNT_W'(1);
            end else if (w_last) begin
                r_acc <= w_sum;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    stereolbm_axis_cambm_sat_shift #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .sum  (w_sum),
        .data (w_res_data),
        .sat  (w_res_sat)
    );

    // Output register: a new result wins over retirement in the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else if (w_step && w_last) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_res_data;
            r_m_sat   <= w_res_sat;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // The ACC_W sizing rule makes a mid-window overflow impossible
    always_ff @(posedge clk) begin
        if (!reset && w_step && (r_cnt != '0)) begin
            assert (!w_ovf);
        end
    end

    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;
    assign m_valid = r_m_valid;

endmodule : stereolbm_axis_cambm_prod_accum
`default_nettype wire

// File: tb/tb_stereolbm_axis_cambm_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_stereolbm_axis_cambm_prod_accum
// Description : Directed self-checking bench. Instance A: WIN_LEN=4,
//               SHIFT=0, MUL_LAT=1. Instance B: WIN_LEN=4, SHIFT=2,
//               MUL_LAT=2. Rounding expectations follow
//               STEREOLBM_ACC_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stereolbm_axis_cambm_prod_accum;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals and a one-stage multiplier model
    logic        s_valid_a = 1'b0, s_ready_a, mul_ce_a, m_sat_a, m_valid_a, m_ready_a = 1'b1;
    logic [31:0] opnd_a = '0, prod_a = '0, m_data_a;

    always @(posedge clk) if (mul_ce_a) prod_a <= opnd_a;

    stereolbm_axis_cambm_prod_accum #(
        .PROD_W(32), .ACC_W(40), .OUT_W(32), .WIN_LEN(4), .SHIFT(0), .MUL_LAT(1)
    ) dut_a (
        .clk(clk), .reset(reset), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .mul_ce(mul_ce_a), .prod(prod_a), .m_data(m_data_a), .m_sat(m_sat_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a)
    );

    // Instance B signals and a two-stage multiplier model
    logic        s_valid_b = 1'b0, s_ready_b, mul_ce_b, m_sat_b, m_valid_b, m_ready_b = 1'b1;
    logic [31:0] opnd_b = '0, stage_b = '0, prod_b = '0, m_data_b;

    always @(posedge clk) if (mul_ce_b) begin
        stage_b <= opnd_b;
        prod_b  <= stage_b;
    end

    stereolbm_axis_cambm_prod_accum #(
        .PROD_W(32), .ACC_W(40), .OUT_W(32), .WIN_LEN(4), .SHIFT(2), .MUL_LAT(2)
    ) dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .mul_ce(mul_ce_b), .prod(prod_b), .m_data(m_data_b), .m_sat(m_sat_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b)
    );

    // Present one operand to A and hold it until accepted
    task automatic send_a(input logic [31:0] v);
        logic rdy;
        @(negedge clk);
        s_valid_a = 1'b1;
        opnd_a    = v;
        for (int i = 0; i < 50; i++) begin
            rdy = s_ready_a;
            @(posedge clk);
            if (rdy) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL send_a_timeout got=stalled want=accepted");
    endtask

    task automatic send_b(input logic [31:0] v);
        logic rdy;
        @(negedge clk);
        s_valid_b = 1'b1;
        opnd_b    = v;
        for (int i = 0; i < 50; i++) begin
            rdy = s_ready_b;
            @(posedge clk);
            if (rdy) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL send_b_timeout got=stalled want=accepted");
    endtask

    // Idle the input and wait (bounded) for the next A result
    task automatic wait_a(output logic ok, output logic [31:0] d, output logic s, output int n);
        ok = 1'b0; d = '0; s = 1'b0; n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_valid_a = 1'b0;
            if (m_valid_a) begin
                ok = 1'b1; d = m_data_a; s = m_sat_a; n = i;
                return;
            end
        end
    endtask

    task automatic wait_b(output logic ok, output logic [31:0] d, output logic s, output int n);
        ok = 1'b0; d = '0; s = 1'b0; n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_valid_b = 1'b0;
            if (m_valid_b) begin
                ok = 1'b1; d = m_data_b; s = m_sat_b; n = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid_a); end
        total++; if (m_data_a !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data_a); end
        total++; if (m_sat_a !== 1'b0) begin bad++; $display("FAIL reset_m_sat got=%b want=0", m_sat_a); end
        total++; if (mul_ce_a !== 1'b1) begin bad++; $display("FAIL reset_mul_ce got=%b want=1", mul_ce_a); end
        total++; if (s_ready_a !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready_a); end
    endtask

    task automatic test_basic;
        logic ok; logic [31:0] d; logic s; int n;
        m_ready_a = 1'b1;
        send_a(32'd3); send_a(32'd5); send_a(-32'sd2); send_a(32'd7);
        wait_a(ok, d, s, n);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout got=none want=result"); end
        total++; if (n != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", n); end
        total++; if (d !== 32'd13) begin bad++; $display("FAIL basic_data got=%0d want=13", $signed(d)); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b want=0", s); end
        @(negedge clk);
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", m_valid_a); end
    endtask

    task automatic test_saturate;
        logic ok; logic [31:0] d; logic s; int n;
        repeat (4) send_a(32'h7FFF_FFFF);
        wait_a(ok, d, s, n);
        total++; if (!ok || d !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos_data got=%h want=7fffffff", d); end
        total++; if (!ok || s !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b want=1", s); end
        repeat (4) send_a(32'h8000_0000);
        wait_a(ok, d, s, n);
        total++; if (!ok || d !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg_data got=%h want=80000000", d); end
        total++; if (!ok || s !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b want=1", s); end
    endtask

    task automatic test_backpressure;
        logic ok; logic [31:0] d; logic s; int n;
        @(negedge clk);
        m_ready_a = 1'b0;
        send_a(32'd1); send_a(32'd2); send_a(32'd3); send_a(32'd4);
        send_a(32'd10);
        @(negedge clk);
        s_valid_a = 1'b1;
        opnd_a    = 32'd20;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m_valid_a !== 1'b1 || m_data_a !== 32'd10 || s_ready_a !== 1'b0 || mul_ce_a !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold got=v%b d%0d rdy%b ce%b want=v1 d10 rdy0 ce0",
                         m_valid_a, m_data_a, s_ready_a, mul_ce_a);
            end
            @(negedge clk);
        end
        m_ready_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid_a = 1'b0;
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL bp_retire got=%b want=0", m_valid_a); end
        send_a(32'd30); send_a(32'd40);
        wait_a(ok, d, s, n);
        total++; if (!ok || d !== 32'd100) begin bad++; $display("FAIL bp_second got=%0d want=100", d); end
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        int idx[2];
        logic [31:0] dat[2];
        m_ready_a = 1'b1;
        fork
            begin
                for (int k = 1; k <= 8; k++) send_a(32'(k));
                @(negedge clk);
                s_valid_a = 1'b0;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    if (m_valid_a) begin
                        if (cnt < 2) begin idx[cnt] = i; dat[cnt] = m_data_a; end
                        cnt++;
                    end
                end
            end
        join
        total++; if (cnt != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", cnt); end
        total++; if (cnt < 1 || dat[0] !== 32'd10) begin bad++; $display("FAIL b2b_first got=%0d want=10", dat[0]); end
        total++; if (cnt < 2 || dat[1] !== 32'd26) begin bad++; $display("FAIL b2b_second got=%0d want=26", dat[1]); end
        total++; if (cnt < 2 || idx[1] - idx[0] != 4) begin bad++; $display("FAIL b2b_spacing got=%0d want=4", idx[1] - idx[0]); end
    endtask

    task automatic test_reset_mid;
        logic ok; logic [31:0] d; logic s; int n;
        send_a(32'd100); send_a(32'd200);
        @(negedge clk);
        s_valid_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", m_valid_a); end
        repeat (4) send_a(32'd1);
        wait_a(ok, d, s, n);
        total++; if (!ok || d !== 32'd4) begin bad++; $display("FAIL rst_mid_data got=%0d want=4", d); end
    endtask

    task automatic test_shift;
        logic ok; logic [31:0] d; logic s; int n;
        logic [31:0] exp_pos, exp_neg;
`ifdef STEREOLBM_ACC_ROUND_EN
        exp_pos = 32'd4;
        exp_neg = 32'hFFFF_FFFD;
`else
        exp_pos = 32'd3;
        exp_neg = 32'hFFFF_FFFC;
`endif
        m_ready_b = 1'b1;
        send_b(32'd2); send_b(32'd3); send_b(32'd4); send_b(32'd5);
        wait_b(ok, d, s, n);
        total++; if (n != 2) begin bad++; $display("FAIL shift_latency got=%0d want=2", n); end
        total++; if (!ok || d !== exp_pos) begin bad++; $display("FAIL shift_pos got=%0d want=%0d", $signed(d), $signed(exp_pos)); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL shift_pos_sat got=%b want=0", s); end
        send_b(-32'sd1); send_b(-32'sd2); send_b(-32'sd3); send_b(-32'sd7);
        wait_b(ok, d, s, n);
        total++; if (!ok || d !== exp_neg) begin bad++; $display("FAIL shift_neg got=%0d want=%0d", $signed(d), $signed(exp_neg)); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturate;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_shift;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stereolbm_axis_cambm_prod_accum
`default_nettype wire
